jk_updown_counter: RTL and testbench

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

---
 rtl/jk_updown_counter_pkg.sv | 29 ++
 rtl/jk_ff.sv | 50 +++++
 rtl/jk_updown_counter.sv | 58 +++++
 tb/tb_jk_updown_counter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/jk_updown_counter_pkg.sv
// Shared types for the JK up/down counter: per-edge operation select and
// the JK excitation encoding understood by jk_ff.
package jk_updown_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_INC   = 2'd2,
    OP_DEC   = 2'd3
  } cnt_op_e;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  // Reset is handled inside each flop, so only load > en > hold is decided here.
  function automatic cnt_op_e sel_op(input logic load, input logic en, input logic up);
    if (load)
      sel_op = OP_LOAD;
    else if (en)
      sel_op = up ? OP_INC : OP_DEC;
    else
      sel_op = OP_HOLD;
  endfunction

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with synchronous active-high reset and a
// complementary output kept in its own register.
module jk_ff
  import jk_updown_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic r_q;
  logic r_qb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= 1'b0;
      r_qb <= 1'b1;
    end else begin
      unique case (jk_cmd_e'({j, k}))
        JK_HOLD: begin
          r_q  <= r_q;
          r_qb <= r_qb;
        end
        JK_CLEAR: begin
          r_q  <= 1'b0;
          r_qb <= 1'b1;
        end
        JK_SET: begin
          r_q  <= 1'b1;
          r_qb <= 1'b0;
        end
        JK_TOGGLE: begin
          r_q  <= r_qb;
          r_qb <= r_q;
        end
        default: begin
          r_q  <= r_q;
          r_qb <= r_qb;
        end
      endcase
    end
  end

  assign q  = r_q;
  assign qb = r_qb;

endmodule

// File: rtl/jk_updown_counter.sv
// Loadable up/down counter whose state lives entirely in per-bit JK flops;
// next state is computed here and converted to minimal J/K excitation.
module jk_updown_counter
  import jk_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  cnt_op_e          w_op;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qb;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  assign w_op = sel_op(load, en, up);

  always_comb begin
    w_next = w_q;
    unique case (w_op)
      OP_LOAD: w_next = din;
      OP_INC:  w_next = w_q + 1'b1;
      OP_DEC:  w_next = w_q - 1'b1;
      OP_HOLD: w_next = w_q;
      default: w_next = w_q;
    endcase
  end

  // Minimal excitation: only bits that change are driven, so J=K=1 never occurs.
  assign w_j = w_next & ~w_q;
  assign w_k = ~w_next & w_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (w_j[g]),
      .k   (w_k[g]),
      .q   (w_q[g]),
      .qb  (w_qb[g])
    );
  end

  assign q    = w_q;
  assign qbar = w_qb;
  assign tc   = up ? (&w_q) : ~(|w_q);

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed self-checking bench for jk_updown_counter (WIDTH=4).
module tb_jk_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] q;
  logic [3:0] qbar;
  logic       tc;

  int unsigned total = 0;
  int unsigned bad = 0;

  jk_updown_counter #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .din  (din),
    .q    (q),
    .qbar (qbar),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then verify the invariants that hold on every cycle.
  task automatic step();
    logic [3:0] w_nq;
    logic [3:0] w_jk;
    @(posedge clk);
    #1;
    w_nq = ~q;
    w_jk = dut.w_j & dut.w_k;
    check("qbar_inv", {12'h0, qbar}, {12'h0, w_nq});
    check("no_jk11", {12'h0, w_jk}, 16'h0);
  endtask

  initial begin
    logic [3:0] exp_q;

    // Reset overrides load
    rst = 1'b1; load = 1'b1; din = 4'hA; en = 1'b1; up = 1'b1;
    step();
    check("rst_q", {12'h0, q}, 16'h0);
    check("rst_qbar", {12'h0, qbar}, 16'h000F);
    check("rst_tc_up", {15'h0, tc}, 16'h0);
    up = 1'b0; #1;
    check("rst_tc_dn", {15'h0, tc}, 16'h1);

    // Up count through wrap: 1..F, 0, 1
    rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      exp_q = 4'(i);
      check("up_q", {12'h0, q}, {12'h0, exp_q});
      check("up_tc", {15'h0, tc}, {15'h0, (exp_q == 4'hF)});
    end

    // Down count through wrap: 1, 0, F, E
    load = 1'b1; din = 4'h1; en = 1'b0;
    step();
    up = 1'b0; #1;
    check("ld1_q", {12'h0, q}, 16'h1);
    check("ld1_tc", {15'h0, tc}, 16'h0);
    load = 1'b0; en = 1'b1;
    step();
    check("dn0_q", {12'h0, q}, 16'h0);
    check("dn0_tc", {15'h0, tc}, 16'h1);
    step();
    check("dnF_q", {12'h0, q}, 16'hF);
    check("dnF_tc", {15'h0, tc}, 16'h0);
    step();
    check("dnE_q", {12'h0, q}, 16'hE);
    check("dnE_qbar", {12'h0, qbar}, 16'h1);

    // Load beats enable
    load = 1'b1; din = 4'h5; en = 1'b0;
    step();
    check("ld5_q", {12'h0, q}, 16'h5);
    load = 1'b1; en = 1'b1; up = 1'b1; din = 4'h9;
    step();
    check("ldpri_q", {12'h0, q}, 16'h9);
    check("ldpri_qbar", {12'h0, qbar}, 16'h6);

    // Hold, then mid-count reset and resume
    load = 1'b1; din = 4'h7; en = 1'b0;
    step();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_q", {12'h0, q}, 16'h7);
    end
    rst = 1'b1; en = 1'b1; up = 1'b1;
    step();
    check("midrst_q", {12'h0, q}, 16'h0);
    check("midrst_qbar", {12'h0, qbar}, 16'hF);
    rst = 1'b0;
    step();
    check("resume_q", {12'h0, q}, 16'h1);

    // A load pulse that ends before the edge must not be captured
    en = 1'b0; load = 1'b1; din = 4'hC;
    #2;
    load = 1'b0;
    step();
    check("glitch_q", {12'h0, q}, 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
